// File: rtl/lc3_mem_responder.sv
// LC-3 memory-side responder: captures a MIO_EN request, waits LATENCY cycles,
// pulses R for one cycle, returns read data, commits writes to RAM or the display.
module lc3_mem_responder #(
  parameter int          ADDR_BITS = 12,
  parameter int          LATENCY   = 2,
  parameter logic [15:0] DSR_ADDR  = 16'hFE04,
  parameter logic [15:0] DDR_ADDR  = 16'hFE06
) (
  input  logic        i_CLK,
  input  logic        i_Reset,
  input  logic        i_MIO_EN,
  input  logic        i_R_W,
  input  logic [15:0] i_MAR,
  input  logic [15:0] i_MDR,
  output logic        o_R,
  output logic [15:0] o_Data,
  output logic        o_Busy,
  output logic        o_Disp_Valid,
  output logic [7:0]  o_Disp_Char
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_READY = 2'd2
  } state_t;

  localparam int         DEPTH    = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1   = (LATENCY > 0) ? 4'(LATENCY - 1) : 4'd0;
  localparam logic       LAT_ZERO = (LATENCY == 0) ? 1'b1 : 1'b0;

  state_t        r_state;
  state_t        w_next;
  logic [3:0]    r_cnt;
  logic [15:0]   r_addr;
  logic [15:0]   r_wdata;
  logic          r_rw;
  logic [15:0]   r_data;
  logic          r_disp_valid;
  logic [7:0]    r_disp_char;
  logic [15:0]   r_mem [0:DEPTH-1];

  logic          w_start;
  logic          w_enter_ready;
  logic [15:0]   w_acc_addr;
  logic [15:0]   w_acc_wdata;
  logic          w_acc_rw;
  logic          w_io;
  logic [15:0]   w_rd_data;

  assign w_start       = (r_state == S_IDLE) && i_MIO_EN;
  assign w_enter_ready = (w_start && LAT_ZERO) || ((r_state == S_WAIT) && (r_cnt == 4'd0));

  // With zero latency READY is entered on the capture edge, so use the live inputs then.
  always_comb begin
    w_acc_addr  = r_addr;
    w_acc_wdata = r_wdata;
    w_acc_rw    = r_rw;
    if (r_state == S_IDLE) begin
      w_acc_addr  = i_MAR;
      w_acc_wdata = i_MDR;
      w_acc_rw    = i_R_W;
    end else begin
      w_acc_addr  = r_addr;
      w_acc_wdata = r_wdata;
      w_acc_rw    = r_rw;
    end
  end

  assign w_io = (w_acc_addr[15:9] == 7'h7F);

  always_comb begin
    w_rd_data = 16'h0000;
    if (w_acc_addr == DSR_ADDR) begin
      w_rd_data = 16'h8000;
    end else if (w_io) begin
      w_rd_data = 16'h0000;
    end else begin
      w_rd_data = r_mem[w_acc_addr[ADDR_BITS-1:0]];
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_start) begin
          w_next = LAT_ZERO ? S_READY : S_WAIT;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_next = S_READY;
        end else begin
          w_next = S_WAIT;
        end
      end
      S_READY: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_addr  <= 16'h0000;
      r_wdata <= 16'h0000;
      r_rw    <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_start) begin
            r_cnt   <= LAT_M1;
            r_addr  <= i_MAR;
            r_wdata <= i_MDR;
            r_rw    <= i_R_W;
          end
        end
        S_WAIT: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_cnt <= 4'd0;
      endcase
    end
  end

  always_ff @(posedge i_CLK or posedge i_Reset) begin
    if (i_Reset) begin
      r_data       <= 16'h0000;
      r_disp_valid <= 1'b0;
      r_disp_char  <= 8'h00;
    end else begin
      r_data       <= (w_enter_ready && !w_acc_rw) ? w_rd_data : 16'h0000;
      r_disp_valid <= w_enter_ready && w_acc_rw && (w_acc_addr == DDR_ADDR);
      if (w_enter_ready && w_acc_rw && (w_acc_addr == DDR_ADDR)) begin
        r_disp_char <= w_acc_wdata[7:0];
      end
    end
  end

  // RAM is deliberately not reset; a write held off by reset is simply dropped.
  always_ff @(posedge i_CLK) begin
    if (w_enter_ready && w_acc_rw && !w_io && !i_Reset) begin
      r_mem[w_acc_addr[ADDR_BITS-1:0]] <= w_acc_wdata;
    end
  end

  assign o_R          = (r_state == S_READY);
  assign o_Busy       = (r_state != S_IDLE);
  assign o_Data       = r_data;
  assign o_Disp_Valid = r_disp_valid;
  assign o_Disp_Char  = r_disp_char;

endmodule

// File: tb/tb_lc3_mem_responder.sv
// Directed bench: one responder with LATENCY=2 and one with LATENCY=0 on a shared bus.
module tb_lc3_mem_responder;

  logic        clk;
  logic        rst;
  logic        en2;
  logic        en0;
  logic        rw_i;
  logic [15:0] mar;
  logic [15:0] mdr;
  logic        sel_r;

  logic        r2, busy2, dv2;
  logic [15:0] data2;
  logic [7:0]  dc2;
  logic        r0, busy0, dv0;
  logic [15:0] data0;
  logic [7:0]  dc0;

  logic        w_R, w_busy, w_dv;
  logic [15:0] w_data;
  logic [7:0]  w_dc;

  int errors = 0;
  int checks = 0;

  lc3_mem_responder #(.LATENCY(2)) u_dut2 (
    .i_CLK(clk), .i_Reset(rst), .i_MIO_EN(en2), .i_R_W(rw_i), .i_MAR(mar), .i_MDR(mdr),
    .o_R(r2), .o_Data(data2), .o_Busy(busy2), .o_Disp_Valid(dv2), .o_Disp_Char(dc2)
  );

  lc3_mem_responder #(.LATENCY(0)) u_dut0 (
    .i_CLK(clk), .i_Reset(rst), .i_MIO_EN(en0), .i_R_W(rw_i), .i_MAR(mar), .i_MDR(mdr),
    .o_R(r0), .o_Data(data0), .o_Busy(busy0), .o_Disp_Valid(dv0), .o_Disp_Char(dc0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb begin
    if (sel_r) begin
      w_R = r0; w_busy = busy0; w_dv = dv0; w_data = data0; w_dc = dc0;
    end else begin
      w_R = r2; w_busy = busy2; w_dv = dv2; w_data = data2; w_dc = dc2;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One complete access; inputs are scrambled after capture to prove they are ignored.
  task automatic access(input bit sel, input bit rw, input logic [15:0] addr,
                        input logic [15:0] wdata, input logic [15:0] exp_data,
                        input int exp_cyc, input string tag);
    int cyc;
    bit got;
    @(negedge clk);
    sel_r = sel; mar = addr; mdr = wdata; rw_i = rw;
    if (sel) en0 = 1'b1; else en2 = 1'b1;
    cyc = 0; got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) begin
        en0 = 1'b0; en2 = 1'b0;
        mar = 16'h0031; mdr = 16'h0000; rw_i = ~rw;
      end
      if (w_R === 1'b1) got = 1'b1;
    end
    chk({tag, "_ready_seen"}, {15'd0, got}, 16'd1);
    chk({tag, "_latency"}, 16'(cyc), 16'(exp_cyc));
    chk({tag, "_data"}, w_data, exp_data);
    chk({tag, "_busy"}, {15'd0, w_busy}, 16'd1);
    chk({tag, "_disp_valid"}, {15'd0, w_dv}, {15'd0, (rw && addr == 16'hFE06)});
    @(negedge clk);
    chk({tag, "_r_one_cycle"}, {15'd0, w_R}, 16'd0);
    chk({tag, "_data_cleared"}, w_data, 16'h0000);
    chk({tag, "_busy_idle"}, {15'd0, w_busy}, 16'd0);
    chk({tag, "_disp_valid_off"}, {15'd0, w_dv}, 16'd0);
  endtask

  initial begin
    int c1;
    int c2;
    rst = 1'b1; en2 = 1'b0; en0 = 1'b0; rw_i = 1'b0;
    mar = 16'h0000; mdr = 16'h0000; sel_r = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Reset state of both instances
    for (int s = 0; s < 2; s++) begin
      sel_r = s[0];
      #1;
      chk("rst_r", {15'd0, w_R}, 16'd0);
      chk("rst_data", w_data, 16'h0000);
      chk("rst_busy", {15'd0, w_busy}, 16'd0);
      chk("rst_dv", {15'd0, w_dv}, 16'd0);
      chk("rst_dc", {8'd0, w_dc}, 16'd0);
    end

    access(1'b0, 1'b1, 16'h0030, 16'hBEEF, 16'h0000, 3, "wr30");
    access(1'b0, 1'b0, 16'h0030, 16'h0000, 16'hBEEF, 3, "rd30");

    access(1'b0, 1'b1, 16'hFE06, 16'h0041, 16'h0000, 3, "wr_ddr");
    chk("disp_char", {8'd0, dc2}, 16'h0041);
    access(1'b0, 1'b0, 16'hFE04, 16'h0000, 16'h8000, 3, "rd_dsr");
    access(1'b0, 1'b0, 16'hFE06, 16'h0000, 16'h0000, 3, "rd_ddr");
    chk("disp_char_hold", {8'd0, dc2}, 16'h0041);

    access(1'b0, 1'b1, 16'h0031, 16'h5555, 16'h0000, 3, "wr31");
    access(1'b0, 1'b1, 16'h0030, 16'hCAFE, 16'h0000, 3, "wr30_cafe");
    access(1'b0, 1'b0, 16'h0030, 16'h0000, 16'hCAFE, 3, "rd30_cafe");
    access(1'b0, 1'b0, 16'h0031, 16'h0000, 16'h5555, 3, "rd31_kept");

    access(1'b1, 1'b1, 16'h0005, 16'h1234, 16'h0000, 1, "l0_wr5");
    access(1'b1, 1'b0, 16'h0005, 16'h0000, 16'h1234, 1, "l0_rd5");

    // Reset in WAIT of a write must drop it
    access(1'b0, 1'b1, 16'h0040, 16'h1111, 16'h0000, 3, "wr40");
    @(negedge clk);
    sel_r = 1'b0; mar = 16'h0040; mdr = 16'h2222; rw_i = 1'b1; en2 = 1'b1;
    @(negedge clk);
    en2 = 1'b0;
    chk("midop_busy_wait", {15'd0, busy2}, 16'd1);
    #2 rst = 1'b1;
    #1;
    chk("midop_r_low", {15'd0, r2}, 16'd0);
    chk("midop_idle", {15'd0, busy2}, 16'd0);
    chk("midop_dc_reset", {8'd0, dc2}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("midop_no_r", {15'd0, r2}, 16'd0);
    end
    access(1'b0, 1'b0, 16'h0040, 16'h0000, 16'h1111, 3, "rd40_kept");

    // Aliasing plus MIO_EN held high for back-to-back reads
    access(1'b0, 1'b1, 16'h1005, 16'h00AA, 16'h0000, 3, "wr1005");
    @(negedge clk);
    sel_r = 1'b0; mar = 16'h0005; rw_i = 1'b0; en2 = 1'b1;
    c1 = 0;
    while (r2 !== 1'b1 && c1 < 20) begin
      @(negedge clk);
      c1++;
    end
    chk("b2b_first_lat", 16'(c1), 16'd3);
    chk("b2b_first_data", data2, 16'h00AA);
    @(negedge clk);
    chk("b2b_idle_r", {15'd0, r2}, 16'd0);
    chk("b2b_idle_busy", {15'd0, busy2}, 16'd0);
    c2 = 0;
    while (r2 !== 1'b1 && c2 < 20) begin
      @(negedge clk);
      c2++;
    end
    en2 = 1'b0;
    chk("b2b_second_lat", 16'(c2), 16'd3);
    chk("b2b_second_data", data2, 16'h00AA);
    @(negedge clk);
    chk("b2b_end_r", {15'd0, r2}, 16'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
